// File: rtl/ndn_pkg.sv
// Shared NDN-lite definitions: packet type bytes, key widths, parser states
// and the request handed to the PIT stage.
package ndn_pkg;

    localparam int PREFIX_W = 64;
    localparam int LEN_W    = 5;

    localparam logic [7:0] TYPE_INTEREST = 8'h05;
    localparam logic [7:0] TYPE_DATA     = 8'h06;

    typedef enum logic [2:0] {
        IDLE,
        NAME_LEN,
        NAME,
        SKIP,
        ISSUE,
        HOLD,
        DROP
    } state_t;

    typedef struct packed {
        logic [PREFIX_W-1:0] prefix;
        logic [LEN_W-1:0]    len;
    } pit_req_t;

    function automatic logic is_known_type(input logic [7:0] t);
        return (t == TYPE_INTEREST) || (t == TYPE_DATA);
    endfunction

endpackage

// File: rtl/ndn_prefix_packer.sv
// Packs the leading name bytes into a left-aligned shadow key; later name
// bytes only advance the byte index.
module ndn_prefix_packer
    import ndn_pkg::*;
#(
    parameter int PREFIX_BYTES = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                wr_en,
    input  logic [7:0]          data,
    output logic [PREFIX_W-1:0] shadow,
    output logic [LEN_W-1:0]    idx
);

    // NOTE: registers are updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            shadow <= '0;
            idx    <= '0;
        end else if (clear) begin
            shadow <= '0;
            idx    <= '0;
        end else if (wr_en) begin
            for (int b = 0; b < PREFIX_BYTES; b++) begin
                if (idx == LEN_W'(b))
                    shadow[PREFIX_W-1-8*b -: 8] <= data;
            end
            idx <= idx + LEN_W'(1);
        end
    end

endmodule

// File: rtl/ndn_prefix_extractor.sv
// Byte-serial NDN-lite header parser feeding the PIT: issues a stable
// {prefix, len} with a one-cycle Interest/Data strobe, then paces ingress.
module ndn_prefix_extractor
    import ndn_pkg::*;
#(
    parameter int PREFIX_BYTES = 8,
    parameter int HOLD_CYCLES  = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          in_data,
    input  logic                in_valid,
    input  logic                in_last,
    output logic                in_ready,
    output logic [PREFIX_W-1:0] prefix,
    output logic [LEN_W-1:0]    len,
    output logic                prefix_ready,
    output logic                out_bit,
    output logic [15:0]         drop_count,
    output logic [15:0]         pkt_count
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    state_t              state, state_nxt;
    pit_req_t            req;
    logic                is_data;
    logic [LEN_W-1:0]    len_sh;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [PREFIX_W-1:0] shadow;
    logic [LEN_W-1:0]    pk_idx;
    logic                pk_clear, pk_wr, len_wr, type_wr, drop_inc;

    ndn_prefix_packer #(.PREFIX_BYTES(PREFIX_BYTES)) u_packer (
        .clk    (clk),
        .rst    (rst),
        .clear  (pk_clear),
        .wr_en  (pk_wr),
        .data   (in_data),
        .shadow (shadow),
        .idx    (pk_idx)
    );

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        pk_clear  = 1'b0;
        pk_wr     = 1'b0;
        len_wr    = 1'b0;
        type_wr   = 1'b0;
        drop_inc  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    // A lone type byte is as malformed as an unknown type.
                    if (in_last) begin
                        drop_inc = 1'b1;
                    end else if (is_known_type(in_data)) begin
                        type_wr   = 1'b1;
                        state_nxt = NAME_LEN;
                    end else begin
                        state_nxt = DROP;
                    end
                end
            end
            NAME_LEN: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (in_data == 8'd0 || in_data > 8'd31 || in_last) begin
                        drop_inc  = in_last;
                        state_nxt = in_last ? IDLE : DROP;
                    end else begin
                        len_wr    = 1'b1;
                        pk_clear  = 1'b1;
                        state_nxt = NAME;
                    end
                end
            end
            NAME: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    pk_wr = 1'b1;
                    if (pk_idx == len_sh - LEN_W'(1)) begin
                        state_nxt = in_last ? ISSUE : SKIP;
                    end else if (in_last) begin
                        drop_inc  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            SKIP: begin
                in_ready = 1'b1;
                if (in_valid && in_last)
                    state_nxt = ISSUE;
            end
            ISSUE: state_nxt = HOLD;
            HOLD: begin
                if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1))
                    state_nxt = IDLE;
            end
            DROP: begin
                in_ready = 1'b1;
                if (in_valid && in_last) begin
                    drop_inc  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (!rst)
            in_ready = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            req          <= '0;
            is_data      <= 1'b0;
            len_sh       <= '0;
            hold_cnt     <= '0;
            prefix_ready <= 1'b0;
            out_bit      <= 1'b0;
            drop_count   <= '0;
            pkt_count    <= '0;
        end else begin
            state        <= state_nxt;
            prefix_ready <= 1'b0;
            out_bit      <= 1'b0;
            if (type_wr)
                is_data <= (in_data == TYPE_DATA);
            // The published len only moves at issue, so it is staged here first.
            if (len_wr)
                len_sh <= in_data[LEN_W-1:0];
            if (state == ISSUE) begin
                req.prefix   <= shadow;
                req.len      <= len_sh;
                prefix_ready <= !is_data;
                out_bit      <= is_data;
                pkt_count    <= pkt_count + 16'd1;
                hold_cnt     <= '0;
            end else if (state == HOLD) begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
            end
            if (drop_inc && drop_count != 16'hFFFF)
                drop_count <= drop_count + 16'd1;
        end
    end

    assign prefix = req.prefix;
    assign len    = req.len;

endmodule

// File: tb/tb_ndn_prefix_extractor.sv
// Randomized packet-level bench for ndn_prefix_extractor with a per-packet
// reference model (issue or drop, expected key) and a strobe monitor.
module tb_ndn_prefix_extractor;

    localparam int HOLD_CYCLES = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic [63:0] prefix;
    logic [4:0]  len;
    logic        prefix_ready;
    logic        out_bit;
    logic [15:0] drop_count;
    logic [15:0] pkt_count;

    ndn_prefix_extractor #(.PREFIX_BYTES(8), .HOLD_CYCLES(HOLD_CYCLES)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .prefix       (prefix),
        .len          (len),
        .prefix_ready (prefix_ready),
        .out_bit      (out_bit),
        .drop_count   (drop_count),
        .pkt_count    (pkt_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_pr  = 0;
    int n_ob  = 0;

    logic [7:0]  pkt[$];
    logic [63:0] exp_prefix = '0;
    logic [4:0]  exp_len    = '0;
    logic [15:0] exp_drop   = '0;
    logic [15:0] exp_pkt    = '0;

    always @(negedge clk) begin
        if (prefix_ready) n_pr++;
        if (out_bit)      n_ob++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Packet-level reference: a packet issues only if it has a known type, a
    // length of 1..31 and at least all L name bytes; anything else is a drop.
    task automatic model_eval(output bit issue, output bit is_data,
                              output logic [63:0] pfx, output logic [4:0] l);
        int n;
        int nl;
        n       = pkt.size();
        issue   = 1'b0;
        is_data = (pkt[0] == 8'h06);
        pfx     = '0;
        l       = '0;
        if (pkt[0] != 8'h05 && pkt[0] != 8'h06) return;
        if (n < 2) return;
        nl = int'(pkt[1]);
        if (nl == 0 || nl > 31) return;
        if (n < 2 + nl) return;
        issue = 1'b1;
        for (int i = 0; i < nl && i < 8; i++)
            pfx[63-8*i -: 8] = pkt[2+i];
        l = 5'(nl);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last, input bit bubbles);
        int w;
        if (bubbles && $urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 2)) @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (w >= 20) check("in_ready_timeout", 64'(w), 64'd0);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic run_pkt(input bit bubbles);
        bit          iss;
        bit          isd;
        logic [63:0] pf;
        logic [4:0]  l;
        int          w;
        int          pr0;
        int          ob0;
        model_eval(iss, isd, pf, l);
        pr0 = n_pr;
        ob0 = n_ob;
        foreach (pkt[i]) send_byte(pkt[i], i == pkt.size() - 1, bubbles);
        if (iss) begin
            exp_pkt++;
            exp_prefix = pf;
            exp_len    = l;
            w = 0;
            while (!(prefix_ready || out_bit) && w < 8) begin
                @(negedge clk);
                w++;
            end
            check("strobe_seen", 64'(w < 8), 64'd1);
            check("prefix", prefix, exp_prefix);
            check("len", 64'(len), 64'(exp_len));
            check("prefix_ready", 64'(prefix_ready), 64'(!isd));
            check("out_bit", 64'(out_bit), 64'(isd));
            check("pkt_count", 64'(pkt_count), 64'(exp_pkt));
            w = 0;
            while (!in_ready && w < 10) begin
                check("hold_prefix", prefix, exp_prefix);
                @(negedge clk);
                w++;
            end
            check("hold_cycles", 64'(w), 64'(HOLD_CYCLES));
            check("strobe_pulses", 64'((n_pr - pr0) + (n_ob - ob0)), 64'd1);
        end else begin
            exp_drop++;
            @(negedge clk);
            check("drop_count", 64'(drop_count), 64'(exp_drop));
            check("drop_in_ready", 64'(in_ready), 64'd1);
            check("drop_prefix", prefix, exp_prefix);
            check("drop_len", 64'(len), 64'(exp_len));
            check("drop_no_strobe", 64'((n_pr - pr0) + (n_ob - ob0)), 64'd0);
            check("drop_pkt_count", 64'(pkt_count), 64'(exp_pkt));
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_prefix"}, prefix, 64'd0);
        check({tag, "_len"}, 64'(len), 64'd0);
        check({tag, "_strobes"}, 64'({prefix_ready, out_bit}), 64'd0);
        check({tag, "_drop"}, 64'(drop_count), 64'd0);
        check({tag, "_pkt"}, 64'(pkt_count), 64'd0);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    endtask

    task automatic gen_random();
        int kind;
        int l;
        logic [7:0] t;
        pkt.delete();
        kind = $urandom_range(0, 5);
        case (kind)
            0, 1, 5: begin
                l = $urandom_range(1, 31);
                pkt.push_back(kind == 1 ? 8'h06 : 8'h05);
                pkt.push_back(8'(l));
                for (int i = 0; i < l; i++) pkt.push_back(8'($urandom));
                for (int i = 0; i < (kind == 5 ? 12 : $urandom_range(0, 4)); i++)
                    pkt.push_back(8'($urandom));
            end
            2: begin
                do t = 8'($urandom); while (t == 8'h05 || t == 8'h06);
                pkt.push_back(t);
                for (int i = 1; i < $urandom_range(1, 6); i++) pkt.push_back(8'($urandom));
            end
            3: begin
                pkt.push_back($urandom_range(0, 1) ? 8'h05 : 8'h06);
                pkt.push_back($urandom_range(0, 1) ? 8'h00 : 8'($urandom_range(32, 255)));
                for (int i = 0; i < $urandom_range(0, 3); i++) pkt.push_back(8'($urandom));
            end
            default: begin
                l = $urandom_range(2, 31);
                pkt.push_back($urandom_range(0, 1) ? 8'h05 : 8'h06);
                pkt.push_back(8'(l));
                for (int i = 0; i < $urandom_range(0, l - 1); i++) pkt.push_back(8'($urandom));
            end
        endcase
    endtask

    initial begin
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b1;
        #1;
        check("reset_release_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);

        pkt = '{8'h05, 8'h03, 8'h61, 8'h62, 8'h63};
        run_pkt(1'b0);
        check("interest_abc_key", prefix, 64'h6162_6300_0000_0000);

        pkt = '{8'h06, 8'h0A, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                8'h08, 8'h09, 8'h0A, 8'hF0, 8'hF1, 8'hF2, 8'hF3};
        run_pkt(1'b0);
        check("data_key", prefix, 64'h0102_0304_0506_0708);

        pkt = '{8'h09, 8'h01, 8'h02, 8'h03, 8'h04};
        run_pkt(1'b0);
        pkt = '{8'h05, 8'h00, 8'h11, 8'h22};
        run_pkt(1'b0);
        pkt = '{8'h05, 8'h20, 8'h11, 8'h22};
        run_pkt(1'b0);
        pkt = '{8'h05, 8'h04, 8'h78};
        run_pkt(1'b0);
        pkt = '{8'h05, 8'h02, 8'h41, 8'h42};
        run_pkt(1'b1);

        // Abandon a Data packet mid-name with reset, then a clean Interest.
        send_byte(8'h06, 1'b0, 1'b0);
        send_byte(8'h05, 1'b0, 1'b0);
        send_byte(8'h01, 1'b0, 1'b0);
        send_byte(8'h02, 1'b0, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check_reset_state("midpkt_reset");
        rst = 1'b1;
        exp_prefix = '0;
        exp_len    = '0;
        exp_drop   = '0;
        exp_pkt    = '0;
        n_pr = 0;
        n_ob = 0;
        @(negedge clk);
        pkt = '{8'h05, 8'h01, 8'h7A, 8'h00};
        run_pkt(1'b0);
        check("post_reset_pr_total", 64'(n_pr), 64'd1);
        check("post_reset_ob_total", 64'(n_ob), 64'd0);

        for (int k = 0; k < 60; k++) begin
            gen_random();
            run_pkt(1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
